// File: rtl/jtag_debug_cmd_queue.sv
// JTAG debug command queue: synchronizes update-DR toggles, queues {ir, sr} commands and presents them one at a time.
// Optional drop counter output enabled by defining JTAG_DEBUG_CMD_DROP_CNT_EN.
module jtag_debug_cmd_queue #(
   parameter int IR_W   = 2,
   parameter int DATA_W = 38,
   parameter int DEPTH  = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      udr_toggle,
   input  logic [IR_W-1:0]           ir_in,
   input  logic [DATA_W-1:0]         sr,
   input  logic                      cmd_ack,
   input  logic                      ovf_clr,
   output logic [DATA_W-1:0]         jdo,
   output logic [IR_W-1:0]           cmd_ir,
   output logic                      cmd_valid,
   output logic [(2**IR_W)-1:0]      take_action,
   output logic [(2**IR_W)-1:0]      take_no_action,
   output logic [$clog2(DEPTH):0]    level,
`ifdef JTAG_DEBUG_CMD_DROP_CNT_EN
   output logic [7:0]                drop_cnt,
`endif
   output logic                      overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int NA = 2**IR_W;
   localparam int EW = IR_W + DATA_W;

   logic [2:0]          sync_q, sync_d;
   logic [EW-1:0]       mem_q [DEPTH];
   logic [EW-1:0]       mem_d [DEPTH];
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]       count_q, count_d;
   logic [DATA_W-1:0]   jdo_q, jdo_d;
   logic [IR_W-1:0]     cmd_ir_q, cmd_ir_d;
   logic                cmd_valid_q, cmd_valid_d;
   logic [NA-1:0]       take_action_q, take_action_d;
   logic [NA-1:0]       take_no_action_q, take_no_action_d;
   logic                overflow_q, overflow_d;

   logic                capture;
   logic                full;
   logic                pop;
   logic                push;
   logic                drop;
   logic [EW-1:0]       head;
   logic [NA-1:0]       onehot;

   always_comb begin
      capture = sync_q[1] ^ sync_q[2];
      full    = (count_q == LW'(DEPTH));
      pop     = (count_q != '0) && (!cmd_valid_q || cmd_ack);
      // A full FIFO still accepts a push when the head leaves in the same cycle.
      push    = capture && (!full || pop);
      drop    = capture && full && !pop;
      head    = mem_q[rd_ptr_q];
      onehot  = NA'(1) << head[EW-1:DATA_W];

      sync_d           = {sync_q[1:0], udr_toggle};
      mem_d            = mem_q;
      wr_ptr_d         = wr_ptr_q;
      rd_ptr_d         = rd_ptr_q;
      jdo_d            = jdo_q;
      cmd_ir_d         = cmd_ir_q;
      cmd_valid_d      = cmd_valid_q;
      take_action_d    = '0;
      take_no_action_d = '0;

      if (push) begin
         mem_d[wr_ptr_q] = {ir_in, sr};
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end

      if (pop) begin
         rd_ptr_d    = rd_ptr_q + AW'(1);
         jdo_d       = head[DATA_W-1:0];
         cmd_ir_d    = head[EW-1:DATA_W];
         cmd_valid_d = 1'b1;
         if (head[DATA_W-1]) take_action_d    = onehot;
         else                take_no_action_d = onehot;
      end else if (cmd_ack) begin
         cmd_valid_d = 1'b0;
      end

      count_d = count_q + LW'(push) - LW'(pop);

      if (drop)         overflow_d = 1'b1;
      else if (ovf_clr) overflow_d = 1'b0;
      else              overflow_d = overflow_q;
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         // Track the live toggle level so leaving reset never looks like an edge.
         sync_q           <= {3{udr_toggle}};
         wr_ptr_q         <= '0;
         rd_ptr_q         <= '0;
         count_q          <= '0;
         jdo_q            <= '0;
         cmd_ir_q         <= '0;
         cmd_valid_q      <= 1'b0;
         take_action_q    <= '0;
         take_no_action_q <= '0;
         overflow_q       <= 1'b0;
      end else begin
         sync_q           <= sync_d;
         wr_ptr_q         <= wr_ptr_d;
         rd_ptr_q         <= rd_ptr_d;
         count_q          <= count_d;
         jdo_q            <= jdo_d;
         cmd_ir_q         <= cmd_ir_d;
         cmd_valid_q      <= cmd_valid_d;
         take_action_q    <= take_action_d;
         take_no_action_q <= take_no_action_d;
         overflow_q       <= overflow_d;
      end
   end

`ifdef JTAG_DEBUG_CMD_DROP_CNT_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop) begin
         if (ovf_clr)                drop_cnt_d = 8'd1;
         else if (drop_cnt_q != '1)  drop_cnt_d = drop_cnt_q + 8'd1;
      end else if (ovf_clr) begin
         drop_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) drop_cnt_q <= '0;
      else       drop_cnt_q <= drop_cnt_d;
   end

   assign drop_cnt = drop_cnt_q;
`endif

   assign jdo            = jdo_q;
   assign cmd_ir         = cmd_ir_q;
   assign cmd_valid      = cmd_valid_q;
   assign take_action    = take_action_q;
   assign take_no_action = take_no_action_q;
   assign level          = count_q;
   assign overflow       = overflow_q;

endmodule

// File: tb/tb_jtag_debug_cmd_queue.sv
// Bench for jtag_debug_cmd_queue: queue-based reference model checked every cycle, plus directed literal checks.
module tb_jtag_debug_cmd_queue;
   localparam int IR_W   = 2;
   localparam int DATA_W = 38;
   localparam int DEPTH  = 4;
   localparam int NA     = 4;
   localparam int LW     = 3;
   localparam int EW     = IR_W + DATA_W;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset      = 1'b1;
   logic              udr_toggle = 1'b0;
   logic [IR_W-1:0]   ir_in      = '0;
   logic [DATA_W-1:0] sr         = '0;
   logic              cmd_ack    = 1'b0;
   logic              ovf_clr    = 1'b0;
   logic [DATA_W-1:0] jdo;
   logic [IR_W-1:0]   cmd_ir;
   logic              cmd_valid;
   logic [NA-1:0]     take_action;
   logic [NA-1:0]     take_no_action;
   logic [LW-1:0]     level;
   logic              overflow;
`ifdef JTAG_DEBUG_CMD_DROP_CNT_EN
   logic [7:0]        drop_cnt;
`endif

   jtag_debug_cmd_queue #(.IR_W(IR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .udr_toggle     (udr_toggle),
      .ir_in          (ir_in),
      .sr             (sr),
      .cmd_ack        (cmd_ack),
      .ovf_clr        (ovf_clr),
      .jdo            (jdo),
      .cmd_ir         (cmd_ir),
      .cmd_valid      (cmd_valid),
      .take_action    (take_action),
      .take_no_action (take_no_action),
      .level          (level),
`ifdef JTAG_DEBUG_CMD_DROP_CNT_EN
      .drop_cnt       (drop_cnt),
`endif
      .overflow       (overflow)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of pending commands plus the presented one.
   bit                m_init = 1'b0;
   logic [EW-1:0]     m_q[$];
   logic              m_h[3];
   logic [DATA_W-1:0] m_jdo;
   logic [IR_W-1:0]   m_ir;
   logic              m_valid;
   logic [NA-1:0]     m_ta, m_tna;
   logic              m_ovf;
   int                m_drops;

   always @(posedge clk) begin : model
      logic          cap, pop, drop;
      logic [EW-1:0] e;
      if (reset) begin
         m_q.delete();
         for (int k = 0; k < 3; k++) m_h[k] = udr_toggle;
         m_jdo = '0; m_ir = '0; m_valid = 1'b0;
         m_ta = '0; m_tna = '0; m_ovf = 1'b0; m_drops = 0;
         m_init = 1'b1;
      end else if (m_init) begin
         cap  = (m_h[1] != m_h[2]);
         pop  = (m_q.size() != 0) && (!m_valid || cmd_ack);
         drop = 1'b0;
         m_ta = '0; m_tna = '0;
         if (pop) begin
            e       = m_q.pop_front();
            m_jdo   = e[DATA_W-1:0];
            m_ir    = e[EW-1:DATA_W];
            m_valid = 1'b1;
            if (e[DATA_W-1]) m_ta  = NA'(1) << m_ir;
            else             m_tna = NA'(1) << m_ir;
         end else if (cmd_ack) begin
            m_valid = 1'b0;
         end
         if (cap) begin
            if (m_q.size() < DEPTH) m_q.push_back({ir_in, sr});
            else                    drop = 1'b1;
         end
         if (drop) begin
            m_ovf   = 1'b1;
            m_drops = ovf_clr ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
         end else if (ovf_clr) begin
            m_ovf   = 1'b0;
            m_drops = 0;
         end
         m_h[2] = m_h[1];
         m_h[1] = m_h[0];
         m_h[0] = udr_toggle;
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         cmp("cmd_valid", 64'(cmd_valid), 64'(m_valid));
         cmp("level", 64'(level), 64'(m_q.size()));
         cmp("jdo", 64'(jdo), 64'(m_jdo));
         cmp("cmd_ir", 64'(cmd_ir), 64'(m_ir));
         cmp("take_action", 64'(take_action), 64'(m_ta));
         cmp("take_no_action", 64'(take_no_action), 64'(m_tna));
         cmp("overflow", 64'(overflow), 64'(m_ovf));
`ifdef JTAG_DEBUG_CMD_DROP_CNT_EN
         cmp("drop_cnt", 64'(drop_cnt), 64'(m_drops));
`endif
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic toggle_cmd(input logic [IR_W-1:0] ir, input logic [DATA_W-1:0] d);
      udr_toggle = ~udr_toggle;
      ir_in      = ir;
      sr         = d;
   endtask

   initial begin
      int since;
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(2);
      cmp("lit_reset_level", 64'(level), 64'd0);
      cmp("lit_reset_valid", 64'(cmd_valid), 64'd0);
      cmp("lit_reset_ovf", 64'(overflow), 64'd0);

      // Single command with MSB set
      toggle_cmd(2'b01, 38'h20_0000_0ABC);
      tick(3);
      cmp("lit_latency_not_yet", 64'(cmd_valid), 64'd0);
      cmp("lit_level_one", 64'(level), 64'd1);
      tick(1);
      cmp("lit_valid", 64'(cmd_valid), 64'd1);
      cmp("lit_jdo", 64'(jdo), 64'h20_0000_0ABC);
      cmp("lit_ta", 64'(take_action), 64'b0010);
      cmp("lit_tna_zero", 64'(take_no_action), 64'd0);
      tick(1);
      cmp("lit_ta_one_cycle", 64'(take_action), 64'd0);
      cmd_ack = 1'b1;
      tick(1);
      cmd_ack = 1'b0;
      cmp("lit_ack_empty_valid", 64'(cmd_valid), 64'd0);
      cmp("lit_ack_jdo_hold", 64'(jdo), 64'h20_0000_0ABC);

      // Command with MSB clear
      toggle_cmd(2'b11, 38'h01_2345_6789);
      tick(4);
      cmp("lit_tna", 64'(take_no_action), 64'b1000);
      cmp("lit_ta_zero", 64'(take_action), 64'd0);
      cmd_ack = 1'b1;
      tick(1);
      cmd_ack = 1'b0;

      // Fill: one presented plus DEPTH queued
      for (int i = 0; i < 5; i++) begin
         toggle_cmd(2'(i), {6'($urandom), 32'($urandom)});
         tick(4);
      end
      cmp("lit_full_level", 64'(level), 64'd4);
      cmp("lit_full_ovf", 64'(overflow), 64'd0);

      // Push and pop together while full
      toggle_cmd(2'b10, 38'h3F_FFFF_0000);
      tick(2);
      cmd_ack = 1'b1;
      tick(1);
      cmd_ack = 1'b0;
      tick(1);
      cmp("lit_pushpop_level", 64'(level), 64'd4);
      cmp("lit_pushpop_ovf", 64'(overflow), 64'd0);

      // Drop while full
      toggle_cmd(2'b00, 38'h00_DEAD_BEEF);
      tick(4);
      cmp("lit_drop_ovf", 64'(overflow), 64'd1);
      cmp("lit_drop_level", 64'(level), 64'd4);
`ifdef JTAG_DEBUG_CMD_DROP_CNT_EN
      cmp("lit_drop_cnt", 64'(drop_cnt), 64'd1);
`endif

      // Clear coincident with drop, then clear alone
      toggle_cmd(2'b01, 38'h12_3456_789A);
      tick(2);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      cmp("lit_clr_drop_ovf", 64'(overflow), 64'd1);
`ifdef JTAG_DEBUG_CMD_DROP_CNT_EN
      cmp("lit_clr_drop_cnt", 64'(drop_cnt), 64'd1);
`endif
      tick(1);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      cmp("lit_clr_ovf", 64'(overflow), 64'd0);

      // Reset mid-operation with a pop due and a toggle in flight
      cmd_ack = 1'b1;
      tick(1);
      cmd_ack = 1'b0;
      cmp("lit_pre_rst_level", 64'(level), 64'd3);
      cmp("lit_pre_rst_valid", 64'(cmd_valid), 64'd1);
      toggle_cmd(2'b11, 38'h25_5555_5555);
      tick(1);
      reset   = 1'b1;
      cmd_ack = 1'b1;
      tick(1);
      reset   = 1'b0;
      cmd_ack = 1'b0;
      cmp("lit_rst_level", 64'(level), 64'd0);
      cmp("lit_rst_valid", 64'(cmd_valid), 64'd0);
      cmp("lit_rst_pulses", 64'({take_action, take_no_action}), 64'd0);
      cmp("lit_rst_jdo", 64'(jdo), 64'd0);
      tick(6);
      cmp("lit_post_rst_level", 64'(level), 64'd0);
      cmp("lit_post_rst_valid", 64'(cmd_valid), 64'd0);

      // Randomized traffic
      since = 10;
      for (int i = 0; i < 1200; i++) begin
         cmd_ack = (i < 600) ? ($urandom_range(7) == 0) : ($urandom_range(3) != 0);
         ovf_clr = ($urandom_range(15) == 0);
         reset   = ($urandom_range(79) == 0);
         if (since >= 4 && $urandom_range(1) == 0) begin
            toggle_cmd(2'($urandom), {6'($urandom), 32'($urandom)});
            since = 0;
         end
         tick(1);
         since++;
      end
      reset   = 1'b0;
      cmd_ack = 1'b0;
      ovf_clr = 1'b0;
      tick(6);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
